ctrl_decode_pipe: RTL and testbench
===================================

# ctrl_decode_pipe

Registered, parameterised successor to the SaRV combinational control unit. It decodes a full 32-bit RV32I instruction, with optional RV32M, into the same control bundle. Decoding happens behind a valid/ready handshake with a 2-entry skid buffer, so the decode stage can be back-pressured by execute. Every output is fully defined on every opcode, and illegal encodings are flagged and counted rather than latched.

## Interface
- `HAS_MEXT`, 0: 1 = decode OP_R with func7=0000001 as MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; 0 = illegal.
- `FENCE_NOP`, 1: 1 = FENCE decodes as legal no-op; 0 = illegal.
- `PC_W`, 32: width of the PC sideband.
- `CNT_W`, 8: width of the saturating illegal-instruction counter.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  drop all buffered entries; has priority over all other inputs.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  instruction PC, carried unchanged.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  consumer accepts.
- `out_pc`  out  PC_W  PC of the bundle.
- `out_alu_ctrl`  out  5  ALU op, `define.v` codes. M-ops use codes 5'h10–5'h17 in func3 order.
- `out_jump`  out  1  JAL/JALR.
- `out_branch`  out  3  {is_branch, invert, unsigned}. Non-branch = 000.
- `out_imm_src`  out  3  IMM12 / IMM12S (store) / IMM13B / IMM20SHIFTED / IMM21J / IMM_SHAMT.
- `out_reg_write`  out  2  00 none, 01 byte, 10 half, 11 word.
- `out_load_unsigned`  out  1  LBU/LHU.
- `out_mem_write`  out  2  00 none, `MEM_WRITE_8/16/32` = 01/10/11.
- `out_alu_src`  out  1  `ALU_IMM`/`ALU_REG`.
- `out_result_src`  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI).
- `out_illegal`  out  1  bundle is an illegal instruction. All write enables forced to 0.
- `ill_count`  out  CNT_W  saturating count of illegal bundles delivered.

## Operation
- Decode is combinational on `in_instr` and is captured on acceptance (`in_valid && in_ready`).
- Every field has a default:
  - alu_ctrl = ADD, alu_src = REG, imm_src = IMM12.
  - All write enables, jump, branch, load_unsigned = 0; result_src = 00.
  - The default is then overridden per opcode.
- OP_R, func7=0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- OP_R, func7=0100000: SUB (func3 000) and SRA (func3 101) only.
- Any other OP_R func7/func3 combination is illegal, except M-ops when `HAS_MEXT`=1.
- OP_IM: SLLI requires func7=0000000. SRLI/SRAI are selected by func7[5]; the other func7 bits must be 0.
- Branches:
  - BEQ/BNE use SUB with branch = 100/110.
  - BLT/BGE use SLT with branch = 100/110.
  - BLTU/BGEU use SLTU with branch = 101/111.
  - func3 010/011 is illegal.
- Loads: func3 000/001/010/100/101 map to reg_write 01/10/11/01/10. load_unsigned = func3[2]. result_src = 01. Other func3 is illegal.
- Stores: func3 000/001/010 map to mem_write 01/10/11 with IMM12S. Other func3 is illegal.
- LUI: reg_write = 11, result_src = 11.
- AUIPC: reg_write = 11, alu_ctrl = ADD, PC operand.
- JAL/JALR: jump = 1, reg_write = 11, result_src = 10. JALR requires func3 = 000.
- SYSTEM and unknown opcodes are illegal.
- An instruction with `in_instr[1:0]` ≠ 11 is illegal.
- Buffering:
  - The output register (OR) drives `out_*`. The skid register (SR) holds one extra entry.
  - `in_ready = !sr_valid` (registered, no combinational path from `out_ready`).
  - Accept while OR is empty or draining: the entry goes to OR.
  - Accept while OR is stalled: the entry goes to SR.
  - When OR drains and SR is valid: SR moves to OR in the same edge.
- Ordering is strictly FIFO.
- `ill_count` increments on `out_valid && out_ready && out_illegal` and saturates at all-ones.
- `flush`:
  - Clears OR and SR valid bits at the next edge.
  - An accept in the same cycle is dropped.
  - `ill_count` is unaffected.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is 1 instruction per cycle when `out_ready` is held high.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1, `ill_count` = 0.
  - All `out_*` bundle fields = default decode (ADD, zeros), `out_pc` = 0.
- `out_*` are stable while `out_valid && !out_ready`.
- Maximum stall buffering is 2 entries. After the second accept under stall, `in_ready` = 0 in the next cycle.
- Simultaneous accept and drain with SR empty: OR reloads with the new entry and no bubble occurs.
- Reset mid-operation: all buffered entries are lost asynchronously and outputs return to reset values immediately.

## Test plan
- Reset then stream with `out_ready`=1:
  - Stimulus: 0x00500093, 0x002081B3, 0x402081B3.
  - Required response: consecutive cycles carrying ADD/ALU_IMM/reg_write 11, then ADD/ALU_REG, then SUB. `ill_count` = 0.
- Branch/memory decode:
  - 0x00208063 → branch = 100, SUB, IMM13B.
  - 0x0020A023 → mem_write = 11, reg_write = 00.
  - 0x00004083 (LBU) → reg_write = 01, load_unsigned = 1, result_src = 01.
- Illegal handling:
  - 0xFFFFFFFF then 0x022081B3 with `HAS_MEXT`=0 → both out_illegal = 1 with all write enables 0. `ill_count` = 2.
  - Same stream with `HAS_MEXT`=1 → second bundle is legal with alu_ctrl = 5'h10.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 and offer 3 instructions.
  - Required response: 2 accepted, `in_ready` = 0 from the 3rd cycle, out_* stable. After `out_ready` is released, the bundles drain in order with no loss or duplication.
- Flush during stall with both entries full:
  - Required response: next cycle `out_valid` = 0 and `in_ready` = 1. The same-cycle offer is not delivered.
- Counter saturation with `CNT_W`=2:
  - Stimulus: 5 illegal bundles delivered.
  - Required response: `ill_count` = 3. Assert `rst` mid-stream → `ill_count` = 0 and `out_valid` = 0 immediately.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
`timescale 1ns/1ps
// RV32I (+ optional RV32M) control decoder captured into a valid/ready stage with a
// 2-entry skid buffer; illegal encodings produce a flagged all-default bundle and are counted.
module ctrl_decode_pipe #(
  parameter bit          HAS_MEXT  = 1'b0,
  parameter bit          FENCE_NOP = 1'b1,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_alu_ctrl,
  output logic             out_jump,
  output logic [2:0]       out_branch,
  output logic [2:0]       out_imm_src,
  output logic [1:0]       out_reg_write,
  output logic             out_load_unsigned,
  output logic [1:0]       out_mem_write,
  output logic             out_alu_src,
  output logic [1:0]       out_result_src,
  output logic             out_illegal,
  output logic [CNT_W-1:0] ill_count
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IM    = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  // ALU codes: {0, alt, funct3} for base ops (SUB = 5'h08, SRA = 5'h0D), {10, funct3} for M-ops
  localparam logic [4:0] ALU_SUB  = 5'h08;
  localparam logic [4:0] ALU_SLT  = 5'h02;
  localparam logic [4:0] ALU_SLTU = 5'h03;

  localparam logic [2:0] IMM12        = 3'd0;
  localparam logic [2:0] IMM12S       = 3'd1;
  localparam logic [2:0] IMM13B       = 3'd2;
  localparam logic [2:0] IMM20SHIFTED = 3'd3;
  localparam logic [2:0] IMM21J       = 3'd4;
  localparam logic [2:0] IMM_SHAMT    = 3'd5;

  localparam logic       ALU_IMM = 1'b1;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  typedef struct packed {
    logic [4:0] alu_ctrl;
    logic       jump;
    logic [2:0] branch;
    logic [2:0] imm_src;
    logic [1:0] reg_write;
    logic       load_unsigned;
    logic [1:0] mem_write;
    logic       alu_src;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr;
  ctrl_t      dec_c;
  logic       ill_c;

  assign opcode       = in_instr[6:0];
  assign funct3       = in_instr[14:12];
  assign funct7       = in_instr[31:25];
  assign unused_instr = ^{in_instr[24:15], in_instr[11:7]};

  // Combinational decode; all-zero struct is the default bundle (ADD, REG, IMM12, no writes)
  always_comb begin
    dec_c = '0;
    ill_c = 1'b0;
    case (opcode)
      OP_R: begin
        dec_c.reg_write = SZ_W;
        if (funct7 == 7'b0000000)
          dec_c.alu_ctrl = {2'b00, funct3};
        else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
          dec_c.alu_ctrl = {2'b01, funct3};
        else if (funct7 == 7'b0000001 && HAS_MEXT)
          dec_c.alu_ctrl = {2'b10, funct3};
        else
          ill_c = 1'b1;
      end
      OP_IM: begin
        dec_c.reg_write = SZ_W;
        dec_c.alu_src   = ALU_IMM;
        dec_c.alu_ctrl  = {1'b0, (funct3 == 3'b101) & funct7[5], funct3};
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_c.imm_src = IMM_SHAMT;
          if ({funct7[6], funct7[4:0]} != 6'd0 || (funct3 == 3'b001 && funct7[5]))
            ill_c = 1'b1;
        end
      end
      OP_BR: begin
        dec_c.imm_src  = IMM13B;
        dec_c.branch   = {1'b1, funct3[0], funct3[1]};
        dec_c.alu_ctrl = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
        if (funct3[2:1] == 2'b01) ill_c = 1'b1;
      end
      OP_LD: begin
        dec_c.alu_src       = ALU_IMM;
        dec_c.result_src    = RES_MEM;
        dec_c.load_unsigned = funct3[2];
        case (funct3)
          3'b000, 3'b100: dec_c.reg_write = SZ_B;
          3'b001, 3'b101: dec_c.reg_write = SZ_H;
          3'b010:         dec_c.reg_write = SZ_W;
          default:        ill_c = 1'b1;
        endcase
      end
      OP_ST: begin
        dec_c.alu_src = ALU_IMM;
        dec_c.imm_src = IMM12S;
        case (funct3)
          3'b000:  dec_c.mem_write = SZ_B;
          3'b001:  dec_c.mem_write = SZ_H;
          3'b010:  dec_c.mem_write = SZ_W;
          default: ill_c = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec_c.reg_write  = SZ_W;
        dec_c.result_src = RES_IMM;
        dec_c.imm_src    = IMM20SHIFTED;
        dec_c.alu_src    = ALU_IMM;
      end
      OP_AUIPC: begin
        dec_c.reg_write = SZ_W;
        dec_c.imm_src   = IMM20SHIFTED;
        dec_c.alu_src   = ALU_IMM;
      end
      OP_JAL: begin
        dec_c.jump       = 1'b1;
        dec_c.reg_write  = SZ_W;
        dec_c.result_src = RES_PC4;
        dec_c.imm_src    = IMM21J;
        dec_c.alu_src    = ALU_IMM;
      end
      OP_JALR: begin
        dec_c.jump       = 1'b1;
        dec_c.reg_write  = SZ_W;
        dec_c.result_src = RES_PC4;
        dec_c.imm_src    = IMM12;
        dec_c.alu_src    = ALU_IMM;
        if (funct3 != 3'b000) ill_c = 1'b1;
      end
      OP_FENCE: begin
        if (!FENCE_NOP) ill_c = 1'b1;
      end
      default: ill_c = 1'b1;
    endcase
    if (ill_c) begin
      dec_c         = '0;
      dec_c.illegal = 1'b1;
    end
  end

  logic            or_valid, sr_valid;
  ctrl_t           or_q, sr_q;
  logic [PC_W-1:0] or_pc, sr_pc;
  logic            accept_c;

  assign in_ready = !sr_valid;
  assign accept_c = in_valid && in_ready;

  // Output/skid registers: OR refills from SR first, otherwise from the input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
      or_q     <= '0;
      sr_q     <= '0;
      or_pc    <= '0;
      sr_pc    <= '0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
    end else if (!or_valid || out_ready) begin
      if (sr_valid) begin
        or_valid <= 1'b1;
        or_q     <= sr_q;
        or_pc    <= sr_pc;
        sr_valid <= 1'b0;
      end else begin
        or_valid <= accept_c;
        if (accept_c) begin
          or_q  <= dec_c;
          or_pc <= in_pc;
        end
      end
    end else if (accept_c) begin
      sr_valid <= 1'b1;
      sr_q     <= dec_c;
      sr_pc    <= in_pc;
    end
  end

  // Saturating count of illegal bundles actually handed to the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ill_count <= '0;
    else if (or_valid && out_ready && or_q.illegal && ill_count != '1)
      ill_count <= ill_count + CNT_W'(1);
  end

  assign out_valid         = or_valid;
  assign out_pc            = or_pc;
  assign out_alu_ctrl      = or_q.alu_ctrl;
  assign out_jump          = or_q.jump;
  assign out_branch        = or_q.branch;
  assign out_imm_src       = or_q.imm_src;
  assign out_reg_write     = or_q.reg_write;
  assign out_load_unsigned = or_q.load_unsigned;
  assign out_mem_write     = or_q.mem_write;
  assign out_alu_src       = or_q.alu_src;
  assign out_result_src    = or_q.result_src;
  assign out_illegal       = or_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for ctrl_decode_pipe: one stimulus stream drives a base instance
// (no M extension, 8-bit counter) and an M-extension instance with a 2-bit counter.
module tb_ctrl_decode_pipe;

  localparam logic [4:0] ALU_ADD = 5'h00, ALU_SLL = 5'h01, ALU_SLT = 5'h02, ALU_SLTU = 5'h03;
  localparam logic [4:0] ALU_XOR = 5'h04, ALU_SRL = 5'h05, ALU_OR  = 5'h06, ALU_AND  = 5'h07;
  localparam logic [4:0] ALU_SUB = 5'h08, ALU_SRA = 5'h0D;
  localparam logic [2:0] IMM12 = 3'd0, IMM12S = 3'd1, IMM13B = 3'd2, IMM20 = 3'd3, IMM21J = 3'd4, IMM_SHAMT = 3'd5;

  typedef struct packed {
    logic [4:0] alu_ctrl;
    logic       jump;
    logic [2:0] branch;
    logic [2:0] imm_src;
    logic [1:0] reg_write;
    logic       load_unsigned;
    logic [1:0] mem_write;
    logic       alu_src;
    logic [1:0] result_src;
    logic       illegal;
  } exp_t;

  typedef struct {
    exp_t        a;
    exp_t        b;
    logic [31:0] pc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [31:0] pc_ctr = 32'h1000;

  logic        in_ready_a, out_valid_a, out_jump_a, out_load_unsigned_a, out_alu_src_a, out_illegal_a;
  logic [31:0] out_pc_a;
  logic [4:0]  out_alu_ctrl_a;
  logic [2:0]  out_branch_a, out_imm_src_a;
  logic [1:0]  out_reg_write_a, out_mem_write_a, out_result_src_a;
  logic [7:0]  ill_count_a;

  logic        in_ready_b, out_valid_b, out_jump_b, out_load_unsigned_b, out_alu_src_b, out_illegal_b;
  logic [31:0] out_pc_b;
  logic [4:0]  out_alu_ctrl_b;
  logic [2:0]  out_branch_b, out_imm_src_b;
  logic [1:0]  out_reg_write_b, out_mem_write_b, out_result_src_b;
  logic [1:0]  ill_count_b;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(.HAS_MEXT(1'b0), .FENCE_NOP(1'b1), .PC_W(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .out_alu_ctrl(out_alu_ctrl_a), .out_jump(out_jump_a),
    .out_branch(out_branch_a), .out_imm_src(out_imm_src_a), .out_reg_write(out_reg_write_a),
    .out_load_unsigned(out_load_unsigned_a), .out_mem_write(out_mem_write_a),
    .out_alu_src(out_alu_src_a), .out_result_src(out_result_src_a),
    .out_illegal(out_illegal_a), .ill_count(ill_count_a));

  ctrl_decode_pipe #(.HAS_MEXT(1'b1), .FENCE_NOP(1'b1), .PC_W(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .out_alu_ctrl(out_alu_ctrl_b), .out_jump(out_jump_b),
    .out_branch(out_branch_b), .out_imm_src(out_imm_src_b), .out_reg_write(out_reg_write_b),
    .out_load_unsigned(out_load_unsigned_b), .out_mem_write(out_mem_write_b),
    .out_alu_src(out_alu_src_b), .out_result_src(out_result_src_b),
    .out_illegal(out_illegal_b), .ill_count(ill_count_b));

  logic [20:0] act_a, act_b;
  assign act_a = {out_alu_ctrl_a, out_jump_a, out_branch_a, out_imm_src_a, out_reg_write_a,
                  out_load_unsigned_a, out_mem_write_a, out_alu_src_a, out_result_src_a, out_illegal_a};
  assign act_b = {out_alu_ctrl_b, out_jump_b, out_branch_b, out_imm_src_b, out_reg_write_b,
                  out_load_unsigned_b, out_mem_write_b, out_alu_src_b, out_result_src_b, out_illegal_b};

  int  total = 0, bad = 0;
  int  cnt_a = 0, cnt_b = 0;
  sb_t q[$];
  sb_t sb_new;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Reference decode, written instruction-by-instruction from the ISA rules
  function automatic exp_t ref_decode(input logic [31:0] i, input bit mext);
    exp_t       e;
    bit         illegal_enc;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    e = '0;
    illegal_enc = (i[1:0] != 2'b11);
    case (op)
      7'h33: begin
        e.reg_write = 2'b11;
        if (f7 == 7'h00) e.alu_ctrl = base_alu(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu_ctrl = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu_ctrl = ALU_SRA;
        else if (f7 == 7'h01 && mext) e.alu_ctrl = 5'h10 + 5'(f3);
        else illegal_enc = 1'b1;
      end
      7'h13: begin
        e.reg_write = 2'b11; e.alu_src = 1'b1; e.alu_ctrl = base_alu(f3);
        if (f3 == 3'd1) begin
          e.imm_src = IMM_SHAMT;
          if (f7 != 7'h00) illegal_enc = 1'b1;
        end else if (f3 == 3'd5) begin
          e.imm_src = IMM_SHAMT;
          if (f7 == 7'h20) e.alu_ctrl = ALU_SRA;
          else if (f7 != 7'h00) illegal_enc = 1'b1;
        end
      end
      7'h63: begin
        e.imm_src = IMM13B;
        case (f3)
          3'd0: begin e.alu_ctrl = ALU_SUB;  e.branch = 3'b100; end
          3'd1: begin e.alu_ctrl = ALU_SUB;  e.branch = 3'b110; end
          3'd4: begin e.alu_ctrl = ALU_SLT;  e.branch = 3'b100; end
          3'd5: begin e.alu_ctrl = ALU_SLT;  e.branch = 3'b110; end
          3'd6: begin e.alu_ctrl = ALU_SLTU; e.branch = 3'b101; end
          3'd7: begin e.alu_ctrl = ALU_SLTU; e.branch = 3'b111; end
          default: illegal_enc = 1'b1;
        endcase
      end
      7'h03: begin
        e.alu_src = 1'b1; e.result_src = 2'b01;
        case (f3)
          3'd0: e.reg_write = 2'b01;
          3'd1: e.reg_write = 2'b10;
          3'd2: e.reg_write = 2'b11;
          3'd4: begin e.reg_write = 2'b01; e.load_unsigned = 1'b1; end
          3'd5: begin e.reg_write = 2'b10; e.load_unsigned = 1'b1; end
          default: illegal_enc = 1'b1;
        endcase
      end
      7'h23: begin
        e.alu_src = 1'b1; e.imm_src = IMM12S;
        if (f3 <= 3'd2) e.mem_write = 2'(f3) + 2'd1;
        else illegal_enc = 1'b1;
      end
      7'h37: begin e.reg_write = 2'b11; e.result_src = 2'b11; e.imm_src = IMM20; e.alu_src = 1'b1; end
      7'h17: begin e.reg_write = 2'b11; e.imm_src = IMM20; e.alu_src = 1'b1; end
      7'h6F: begin e.jump = 1'b1; e.reg_write = 2'b11; e.result_src = 2'b10; e.imm_src = IMM21J; e.alu_src = 1'b1; end
      7'h67: begin
        e.jump = 1'b1; e.reg_write = 2'b11; e.result_src = 2'b10; e.imm_src = IMM12; e.alu_src = 1'b1;
        if (f3 != 3'd0) illegal_enc = 1'b1;
      end
      7'h0F: ;
      default: illegal_enc = 1'b1;
    endcase
    if (illegal_enc) begin
      e = '0;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0:  ;
      1:  w[6:0] = 7'h33;
      2:  w[6:0] = 7'h13;
      3:  w[6:0] = 7'h63;
      4:  w[6:0] = 7'h03;
      5:  w[6:0] = 7'h23;
      6:  w[6:0] = 7'h37;
      7:  w[6:0] = 7'h17;
      8:  w[6:0] = 7'h6F;
      9:  w[6:0] = 7'h67;
      10: w[6:0] = 7'h0F;
      default: w[6:0] = 7'h73;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 19) == 0) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  // Scoreboard: record expected bundle on every accepted offer, drop everything on flush
  always @(posedge clk) begin
    if (!rst) begin
      if (flush) q.delete();
      else if (in_valid && in_ready_a) begin
        sb_new.a  = ref_decode(in_instr, 1'b0);
        sb_new.b  = ref_decode(in_instr, 1'b1);
        sb_new.pc = in_pc;
        q.push_back(sb_new);
      end
    end
  end

  // Monitor: compare presented bundles against the queue head, retire on handshake
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      chk("in_ready_a", in_ready_a, q.size() < 2);
      chk("in_ready_b", in_ready_b, q.size() < 2);
      chk("out_valid_a", out_valid_a, q.size() != 0);
      chk("out_valid_b", out_valid_b, q.size() != 0);
      chk("ill_count_a", ill_count_a, cnt_a);
      chk("ill_count_b", ill_count_b, cnt_b);
      if (q.size() != 0) begin
        chk("bundle_a", act_a, q[0].a);
        chk("bundle_b", act_b, q[0].b);
        chk("out_pc_a", out_pc_a, q[0].pc);
        chk("out_pc_b", out_pc_b, q[0].pc);
        if (out_ready) begin
          if (q[0].a.illegal && cnt_a != 255) cnt_a++;
          if (q[0].b.illegal && cnt_b != 3) cnt_b++;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] ins, input bit rdy, input bit fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc_ctr;
    pc_ctr    = pc_ctr + 32'd4;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] p0;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid_a, 0);
    chk("rst in_ready", in_ready_a, 1);
    chk("rst ill_count", ill_count_a, 0);
    chk("rst bundle", act_a, 0);
    chk("rst out_pc", out_pc_a, 0);
    rst = 1'b0;

    drive(1, 32'h00500093, 1, 0);
    chk("addi valid", out_valid_a, 1);
    chk("addi alu", out_alu_ctrl_a, ALU_ADD);
    chk("addi alu_src", out_alu_src_a, 1);
    chk("addi reg_write", out_reg_write_a, 2'b11);
    drive(1, 32'h002081B3, 1, 0);
    chk("add alu", out_alu_ctrl_a, ALU_ADD);
    chk("add alu_src", out_alu_src_a, 0);
    drive(1, 32'h402081B3, 1, 0);
    chk("sub alu", out_alu_ctrl_a, ALU_SUB);
    drive(0, 32'h0, 1, 0);
    chk("stream ill_count", ill_count_a, 0);

    drive(1, 32'h00208063, 1, 0);
    chk("beq branch", out_branch_a, 3'b100);
    chk("beq alu", out_alu_ctrl_a, ALU_SUB);
    chk("beq imm", out_imm_src_a, IMM13B);
    drive(1, 32'h0020A023, 1, 0);
    chk("sw mem_write", out_mem_write_a, 2'b11);
    chk("sw reg_write", out_reg_write_a, 2'b00);
    drive(1, 32'h00004083, 1, 0);
    chk("lbu reg_write", out_reg_write_a, 2'b01);
    chk("lbu unsigned", out_load_unsigned_a, 1);
    chk("lbu result_src", out_result_src_a, 2'b01);

    drive(1, 32'hFFFFFFFF, 1, 0);
    chk("ones illegal", out_illegal_a, 1);
    chk("ones reg_write", out_reg_write_a, 0);
    chk("ones mem_write", out_mem_write_a, 0);
    drive(1, 32'h022081B3, 1, 0);
    chk("mul illegal base", out_illegal_a, 1);
    chk("mul reg_write base", out_reg_write_a, 0);
    chk("mul illegal mext", out_illegal_b, 0);
    chk("mul alu mext", out_alu_ctrl_b, 5'h10);
    drive(0, 32'h0, 1, 0);
    chk("illegal ill_count", ill_count_a, 2);

    p0 = pc_ctr;
    drive(1, 32'h00100113, 0, 0);
    drive(1, 32'h00310233, 0, 0);
    chk("bp in_ready", in_ready_a, 0);
    drive(1, 32'h40520333, 0, 0);
    chk("bp in_ready held", in_ready_a, 0);
    chk("bp out_pc stable", out_pc_a, p0);
    drive(0, 32'h0, 1, 0);
    chk("bp second out_pc", out_pc_a, p0 + 32'd4);
    drive(0, 32'h0, 1, 0);
    chk("bp drained", out_valid_a, 0);

    drive(1, 32'h00100113, 0, 0);
    drive(1, 32'h00310233, 0, 0);
    drive(1, 32'h40520333, 0, 1);
    chk("flush out_valid", out_valid_a, 0);
    chk("flush in_ready", in_ready_a, 1);
    drive(0, 32'h0, 1, 0);
    chk("flush no delivery", out_valid_a, 0);
    drive(1, 32'h00100113, 0, 0);
    drive(1, 32'h00310233, 1, 1);
    chk("flush drops accept", out_valid_a, 0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) drive(1, 32'hFFFFFFFF, 1, 0);
    drive(0, 32'h0, 1, 0);
    chk("sat ill_count_b", ill_count_b, 3);
    chk("sat ill_count_a", ill_count_a, 5);

    drive(1, 32'hFFFFFFFF, 0, 0);
    drive(1, 32'h00500093, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", out_valid_a, 0);
    chk("mid rst ill_count", ill_count_b, 0);
    chk("mid rst in_ready", in_ready_a, 1);
    chk("mid rst bundle", act_a, 0);
    chk("mid rst out_pc", out_pc_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int n = 0; n < 3000; n++)
      drive($urandom_range(0, 9) < 7, gen_instr(), $urandom_range(0, 9) < 6, $urandom_range(0, 59) == 0);
    for (int n = 0; n < 500; n++)
      drive($urandom_range(0, 9) < 8, gen_instr(), 1, 0);
    for (int n = 0; n < 4; n++)
      drive(0, 32'h0, 1, 0);
    chk("final queue empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
